// File: rtl/eth_frame_arb2.sv
// Frame-atomic 2:1 arbiter for 36-bit framed streams {occ,eof,sof,data}.
// Grants one requester per frame and switches only after an eof word has been accepted downstream.
module eth_frame_arb2 #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [35:0]      data0_i,
    input  logic             src_rdy0_i,
    output logic             dst_rdy0_o,
    input  logic [35:0]      data1_i,
    input  logic             src_rdy1_i,
    output logic             dst_rdy1_o,
    output logic [35:0]      dataout,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic             busy,
    output logic [CNT_W-1:0] frames_out
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SEND0 = 2'd1,
        ARB_SEND1 = 2'd2
    } arb_state_t;

    arb_state_t state;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       xfer0;
    logic       xfer1;

    // in0 wins when alone, under fixed priority, or when in1 held the previous grant.
    assign grant0 = src_rdy0_i & (~src_rdy1_i | (PRIO_MODE != 0) | last_grant);
    assign grant1 = src_rdy1_i & ~grant0;

    assign xfer0 = src_rdy0_i & dst_rdy0_o;
    assign xfer1 = src_rdy1_i & dst_rdy1_o;
    assign busy  = (state != ARB_IDLE);

    always_comb begin
        dataout    = 36'h0;
        src_rdy_o  = 1'b0;
        dst_rdy0_o = 1'b0;
        dst_rdy1_o = 1'b0;
        case (state)
            ARB_SEND0: begin
                dataout    = data0_i;
                src_rdy_o  = src_rdy0_i;
                dst_rdy0_o = dst_rdy_i;
            end
            ARB_SEND1: begin
                dataout    = data1_i;
                src_rdy_o  = src_rdy1_i;
                dst_rdy1_o = dst_rdy_i;
            end
            default: begin
            end
        endcase
    end

    // The idle cycle between frames is where arbitration happens; the unused code 3 falls back to idle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            frames_out <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant0) begin
                        state      <= ARB_SEND0;
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        state      <= ARB_SEND1;
                        last_grant <= 1'b1;
                    end
                end
                ARB_SEND0: begin
                    if (xfer0 && data0_i[33]) begin
                        state      <= ARB_IDLE;
                        frames_out <= frames_out + CNT_W'(1);
                    end
                end
                ARB_SEND1: begin
                    if (xfer1 && data1_i[33]) begin
                        state      <= ARB_IDLE;
                        frames_out <= frames_out + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
